// File: rtl/tpu_pkg.sv
// Shared TPU control-path types: the instruction word and its reset value.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package tpu_pkg;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [31:0] length;
    logic [15:0] acc_addr;
    logic [23:0] buffer_addr;
  } instr_type;

  localparam instr_type INIT_INSTR = '{
    opcode:      8'h00,
    length:      32'd0,
    acc_addr:    16'h0000,
    buffer_addr: 24'h00_0000
  };

endpackage

// File: rtl/instruction_dispatcher.sv
// Pops instructions from the instruction FIFO, decodes them and issues in program order
// to the weight / MMU / activation controllers; SYNC, HALT, NOP handled locally.
// Latency: pop, capture and issue on three consecutive edges (>= 4 cycles between issues).
// Backpressure: target busy / resource_busy stalls DISPATCH, and every later instruction with it.
//
// Ports:
//   clk, rst (async, active-low), enable (freezes FSM when low)
//   instr_in / instr_empty / instr_read : FIFO read side (data valid the cycle after the pop)
//   instr_out : captured instruction shared by all controllers
//   *_instr_enable : one-cycle issue pulses; *_busy, *_resource_busy : controller status
//   synchronize / illegal_opcode : one-cycle pulses; halted : sticky
//   issued_count : wrapping issue counter; busy : combinational activity flag
module instruction_dispatcher
  import tpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  instr_type   instr_in,
  input  logic        instr_empty,
  output logic        instr_read,
  output instr_type   instr_out,
  output logic        weight_instr_enable,
  output logic        mmu_instr_enable,
  output logic        act_instr_enable,
  input  logic        weight_busy,
  input  logic        weight_resource_busy,
  input  logic        mmu_busy,
  input  logic        mmu_resource_busy,
  input  logic        act_busy,
  output logic        synchronize,
  output logic        halted,
  output logic        illegal_opcode,
  output logic [31:0] issued_count,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CAPTURE, S_DISPATCH, S_SYNC_WAIT, S_HALT_WAIT, S_HALTED
  } state_t;

  typedef enum logic [2:0] {
    K_NOP, K_SYNC, K_HALT, K_LOAD, K_MATMUL, K_ACT, K_ILLEGAL
  } kind_t;

  state_t      r_state, w_next_state;
  instr_type   r_instr, w_instr;
  logic        r_read, w_read;
  logic        r_weight_en, w_weight_en;
  logic        r_mmu_en, w_mmu_en;
  logic        r_act_en, w_act_en;
  logic        r_sync, w_sync;
  logic        r_halted, w_halted;
  logic        r_illegal, w_illegal;
  logic [31:0] r_count, w_count;
  kind_t       w_kind;
  logic        w_len_zero;
  logic        w_all_idle;

  assign w_len_zero = (r_instr.length == 32'd0);
  assign w_all_idle = !(weight_busy || weight_resource_busy || mmu_busy ||
                        mmu_resource_busy || act_busy);

  // Priority order matters: 8'hFF would otherwise fall into the ACTIVATE range.
  always_comb begin
    if (r_instr.opcode == 8'h00)                w_kind = K_NOP;
    else if (r_instr.opcode == 8'h01)           w_kind = K_SYNC;
    else if (r_instr.opcode == 8'hFF)           w_kind = K_HALT;
    else if (r_instr.opcode[7:3] == 5'b00001)   w_kind = K_LOAD;
    else if (r_instr.opcode[7:4] == 4'b0010)    w_kind = K_MATMUL;
    else if (r_instr.opcode[7])                 w_kind = K_ACT;
    else                                        w_kind = K_ILLEGAL;
  end

  always_comb begin
    w_next_state = r_state;
    w_instr      = r_instr;
    w_read       = 1'b0;
    w_weight_en  = 1'b0;
    w_mmu_en     = 1'b0;
    w_act_en     = 1'b0;
    w_sync       = 1'b0;
    w_halted     = r_halted;
    w_illegal    = 1'b0;
    w_count      = r_count;
    // With enable low nothing advances, so every pulse is implicitly suppressed.
    if (enable) begin
      case (r_state)
        S_IDLE: begin
          // The pop is launched on this edge so it is presented during FETCH; the FIFO
          // read data then holds until CAPTURE even if FETCH is frozen by enable.
          if (!instr_empty) begin
            w_read       = 1'b1;
            w_next_state = S_FETCH;
          end
        end
        S_FETCH:   w_next_state = S_CAPTURE;
        S_CAPTURE: begin
          w_instr      = instr_in;
          w_next_state = S_DISPATCH;
        end
        S_DISPATCH: begin
          // Default is to consume (NOP, illegal, zero length); a blocked issue stays here.
          w_next_state = S_IDLE;
          case (w_kind)
            K_LOAD: if (!w_len_zero) begin
              if (!weight_busy) begin
                w_weight_en = 1'b1;
                w_count     = r_count + 32'd1;
              end else begin
                w_next_state = S_DISPATCH;
              end
            end
            K_MATMUL: if (!w_len_zero) begin
              if (!mmu_busy && !weight_resource_busy) begin
                w_mmu_en = 1'b1;
                w_count  = r_count + 32'd1;
              end else begin
                w_next_state = S_DISPATCH;
              end
            end
            K_ACT: if (!w_len_zero) begin
              if (!act_busy && !mmu_resource_busy) begin
                w_act_en = 1'b1;
                w_count  = r_count + 32'd1;
              end else begin
                w_next_state = S_DISPATCH;
              end
            end
            K_SYNC:    w_next_state = S_SYNC_WAIT;
            K_HALT:    w_next_state = S_HALT_WAIT;
            K_ILLEGAL: w_illegal    = 1'b1;
            default:   ;
          endcase
        end
        S_SYNC_WAIT: begin
          if (w_all_idle) begin
            w_sync       = 1'b1;
            w_next_state = S_IDLE;
          end
        end
        S_HALT_WAIT: begin
          if (w_all_idle) begin
            w_halted     = 1'b1;
            w_next_state = S_HALTED;
          end
        end
        default: ;  // S_HALTED is terminal
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_instr     <= INIT_INSTR;
      r_read      <= 1'b0;
      r_weight_en <= 1'b0;
      r_mmu_en    <= 1'b0;
      r_act_en    <= 1'b0;
      r_sync      <= 1'b0;
      r_halted    <= 1'b0;
      r_illegal   <= 1'b0;
      r_count     <= 32'd0;
    end else begin
      r_state     <= w_next_state;
      r_instr     <= w_instr;
      r_read      <= w_read;
      r_weight_en <= w_weight_en;
      r_mmu_en    <= w_mmu_en;
      r_act_en    <= w_act_en;
      r_sync      <= w_sync;
      r_halted    <= w_halted;
      r_illegal   <= w_illegal;
      r_count     <= w_count;
    end
  end

  assign instr_read          = r_read;
  assign instr_out           = r_instr;
  assign weight_instr_enable = r_weight_en;
  assign mmu_instr_enable    = r_mmu_en;
  assign act_instr_enable    = r_act_en;
  assign synchronize         = r_sync;
  assign halted              = r_halted;
  assign illegal_opcode      = r_illegal;
  assign issued_count        = r_count;
  assign busy                = (r_state != S_IDLE) || weight_busy || mmu_busy || act_busy;

endmodule
